// File: rtl/servile_sram_wb_arbiter_pkg.sv
// Shared types and constants for the serial-RF / dual-Wishbone SRAM arbiter.
// Single-cycle combinational helpers only; no state lives here.
package servile_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam int   BEATS = 4;
  localparam logic M0    = 1'b0;
  localparam logic M1    = 1'b1;

endpackage

// File: rtl/servile_sram_wb_arbiter_if.sv
// 32-bit Wishbone-style word port with byte selects and a one-cycle ack.
// The master holds adr/dat/sel/we stable from stb until ack; there is no other backpressure.
interface servile_sram_wb_arbiter_if #(
  parameter int AW = 8
);
  logic [AW-3:0] adr;
  logic [31:0]   dat;
  logic [3:0]    sel;
  logic          we;
  logic          stb;
  logic [31:0]   rdt;
  logic          ack;

  modport master (output adr, dat, sel, we, stb, input rdt, ack);
  modport slave  (input adr, dat, sel, we, stb, output rdt, ack);
endinterface

// File: rtl/servile_sram_wb_arbiter_rr_arb2.sv
// Two-requester round-robin pick; combinational grant, last-grant register updated on ack.
// A tie goes to the master that was not served last; a single requester always wins.
module servile_rr_arb2
  import servile_arb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_ack,
  input  logic       i_ack_gnt,
  output logic       o_gnt
);

  logic r_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      r_last <= M1;
    else if (i_ack) r_last <= i_ack_gnt;
  end

  always_comb begin
    o_gnt = i_req[1];
    if (&i_req) o_gnt = ~r_last;
  end

endmodule

// File: rtl/servile_sram_wb_arbiter.sv
// One byte-wide SRAM shared by the serial RF (always wins) and two Wishbone masters moved as 4 byte beats.
// Write ack 5 cycles after stb is sampled, read ack 6; each RF-active cycle during XFER stalls one beat.
module servile_sram_wb_arbiter
  import servile_arb_pkg::*;
#(
  parameter int depth    = 256,
  parameter int rf_regs  = 32,
  parameter int rf_depth = $clog2(rf_regs * 4),
  parameter int aw       = $clog2(depth)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [rf_depth-1:0] i_rf_waddr,
  input  logic [rf_depth-1:0] i_rf_raddr,
  input  logic [7:0]          i_rf_wdata,
  input  logic                i_rf_wen,
  input  logic                i_rf_ren,
  output logic [7:0]          o_rf_rdata,
  output logic [aw-1:0]       o_sram_waddr,
  output logic [aw-1:0]       o_sram_raddr,
  output logic [7:0]          o_sram_wdata,
  output logic                o_sram_wen,
  output logic                o_sram_ren,
  input  logic [7:0]          i_sram_rdata,
  servile_sram_wb_arbiter_if.slave i_m0,
  servile_sram_wb_arbiter_if.slave i_m1
);

  state_t        r_state;
  logic          r_grant;
  logic [1:0]    r_beat;
  logic          r_rd_pend;
  logic [1:0]    r_rd_idx;
  logic [31:0]   r_rdt;
  logic          r_ack0;
  logic          r_ack1;
  logic          r_regzero;

  logic          w_rf_active;
  logic          w_gnt;
  logic          w_issue;
  logic [aw-3:0] w_adr;
  logic [31:0]   w_dat;
  logic [3:0]    w_sel;
  logic          w_we;
  logic [aw-1:0] w_wb_addr;

  assign w_rf_active = i_rf_wen | i_rf_ren;
  assign w_adr       = r_grant ? i_m1.adr : i_m0.adr;
  assign w_dat       = r_grant ? i_m1.dat : i_m0.dat;
  assign w_sel       = r_grant ? i_m1.sel : i_m0.sel;
  assign w_we        = r_grant ? i_m1.we  : i_m0.we;
  assign w_wb_addr   = {w_adr, r_beat};
  assign w_issue     = (r_state == XFER) & ~w_rf_active;

  servile_rr_arb2 u_arb (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_req     ({i_m1.stb, i_m0.stb}),
    .i_ack     (r_state == ACK),
    .i_ack_gnt (r_grant),
    .o_gnt     (w_gnt)
  );

  // RF lives in the top of the SRAM, so its byte address is inverted into the upper region.
  always_comb begin
    o_sram_waddr = w_wb_addr;
    o_sram_raddr = w_wb_addr;
    o_sram_wdata = w_dat[8*r_beat +: 8];
    o_sram_wen   = w_issue & w_we & w_sel[r_beat];
    o_sram_ren   = w_issue & ~w_we;
    if (w_rf_active) begin
      o_sram_waddr = ~aw'(i_rf_waddr);
      o_sram_raddr = ~aw'(i_rf_raddr);
      o_sram_wdata = i_rf_wdata;
      o_sram_wen   = i_rf_wen;
      o_sram_ren   = i_rf_ren;
    end
  end

  assign o_rf_rdata = r_regzero ? 8'h00 : i_sram_rdata;
  assign i_m0.rdt   = r_rdt;
  assign i_m1.rdt   = r_rdt;
  assign i_m0.ack   = r_ack0;
  assign i_m1.ack   = r_ack1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_grant   <= M0;
      r_beat    <= 2'd0;
      r_rd_pend <= 1'b0;
      r_rd_idx  <= 2'd0;
      r_rdt     <= 32'h0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_regzero <= 1'b0;
    end else begin
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_rd_pend <= 1'b0;
      r_regzero <= &i_rf_raddr[rf_depth-1:2];
      // SRAM data lags ren by one cycle, so capture follows the issued beat regardless of RF traffic now.
      if (r_rd_pend) r_rdt[8*r_rd_idx +: 8] <= i_sram_rdata;
      case (r_state)
        IDLE: begin
          if (i_m0.stb | i_m1.stb) begin
            r_grant <= w_gnt;
            r_beat  <= 2'd0;
            r_state <= XFER;
          end
        end
        XFER: begin
          if (!w_rf_active) begin
            r_beat <= r_beat + 2'd1;
            if (!w_we) begin
              r_rd_pend <= 1'b1;
              r_rd_idx  <= r_beat;
            end
            if (r_beat == 2'(BEATS - 1)) begin
              if (w_we) begin
                r_state <= ACK;
                r_ack0  <= ~r_grant;
                r_ack1  <= r_grant;
              end else begin
                r_state <= DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          r_state <= ACK;
          r_ack0  <= ~r_grant;
          r_ack1  <= r_grant;
        end
        ACK:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_servile_sram_wb_arbiter.sv
// Directed bench: SRAM model plus write/read scoreboards checked by a negedge monitor.
module tb_servile_sram_wb_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_init;
  logic [6:0] rf_waddr, rf_raddr;
  logic [7:0] rf_wdata, rf_rdata;
  logic       rf_wen, rf_ren;
  logic [7:0] sram_waddr, sram_raddr, sram_wdata, sram_rdata;
  logic       sram_wen, sram_ren;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] rq[$];
  logic [7:0] mem   [256];
  logic [7:0] model [256];

  always #5 clk = ~clk;

  servile_sram_wb_arbiter_if #(.AW(8)) m0_if ();
  servile_sram_wb_arbiter_if #(.AW(8)) m1_if ();

  servile_sram_wb_arbiter dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rf_waddr   (rf_waddr),
    .i_rf_raddr   (rf_raddr),
    .i_rf_wdata   (rf_wdata),
    .i_rf_wen     (rf_wen),
    .i_rf_ren     (rf_ren),
    .o_rf_rdata   (rf_rdata),
    .o_sram_waddr (sram_waddr),
    .o_sram_raddr (sram_raddr),
    .o_sram_wdata (sram_wdata),
    .o_sram_wen   (sram_wen),
    .o_sram_ren   (sram_ren),
    .i_sram_rdata (sram_rdata),
    .i_m0         (m0_if),
    .i_m1         (m1_if)
  );

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
      sram_rdata <= 8'h00;
    end else begin
      if (sram_wen) mem[sram_waddr] <= sram_wdata;
      if (sram_ren) sram_rdata <= mem[sram_raddr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sram_wen) begin
      if (wq.size() == 0) chk("unexpected sram wen", 32'(sram_wen), 32'd0);
      else begin
        wr_t e;
        e = wq.pop_front();
        chk("sram waddr", 32'(sram_waddr), 32'(e.a));
        chk("sram wdata", 32'(sram_wdata), 32'(e.d));
      end
    end
    if (sram_ren) begin
      if (rq.size() == 0) chk("unexpected sram ren", 32'(sram_ren), 32'd0);
      else begin
        logic [7:0] a;
        a = rq.pop_front();
        chk("sram raddr", 32'(sram_raddr), 32'(a));
      end
    end
  end

  task automatic set_req(input int m, input bit stb, input bit we, input logic [5:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
    if (m == 0) begin
      m0_if.stb = stb; m0_if.we = we; m0_if.adr = adr; m0_if.dat = dat; m0_if.sel = sel;
    end else begin
      m1_if.stb = stb; m1_if.we = we; m1_if.adr = adr; m1_if.dat = dat; m1_if.sel = sel;
    end
  endtask

  task automatic push_wb(input bit we, input logic [5:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] exp_rdt);
    for (int b = 0; b < 4; b++) begin
      logic [7:0] a;
      a = {adr, 2'(b)};
      if (we) begin
        if (sel[b]) begin
          wq.push_back('{a: a, d: dat[8*b +: 8]});
          model[a] = dat[8*b +: 8];
        end
      end else begin
        rq.push_back(a);
      end
      exp_rdt[8*b +: 8] = model[a];
    end
  endtask

  // rf_mask bit n makes cycle n (counted from the stb sampling edge) an RF write to register byte 0.
  task automatic run_xfer(input string tag, input int m, input bit we, input logic [5:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel, input logic [31:0] rf_mask);
    logic [31:0] exp_rdt;
    int ack_cyc, exp_cyc;
    push_wb(we, adr, dat, sel, exp_rdt);
    for (int n = 1; n < 30; n++) begin
      if (rf_mask[n]) begin
        wq.push_back('{a: 8'hFF, d: 8'(n * 17)});
        model[255] = 8'(n * 17);
      end
    end
    exp_cyc = (we ? 5 : 6) + $countones(rf_mask);
    ack_cyc = -1;
    @(posedge clk) #1;
    set_req(m, 1'b1, we, adr, dat, sel);
    for (int n = 1; n < 30; n++) begin
      @(posedge clk) #1;
      rf_wen   = rf_mask[n];
      rf_waddr = 7'h00;
      rf_raddr = 7'h00;
      rf_wdata = 8'(n * 17);
      @(negedge clk);
      if ((m == 0) ? m0_if.ack : m1_if.ack) begin
        ack_cyc = n;
        break;
      end
    end
    chk({tag, " ack cycle"}, 32'(ack_cyc), 32'(exp_cyc));
    chk({tag, " other ack"}, 32'((m == 0) ? m1_if.ack : m0_if.ack), 32'd0);
    if (!we) chk({tag, " rdt"}, (m == 0) ? m0_if.rdt : m1_if.rdt, exp_rdt);
    set_req(m, 1'b0, we, adr, dat, sel);
    rf_wen = 1'b0;
    @(negedge clk);
    chk({tag, " ack one cycle"}, 32'((m == 0) ? m0_if.ack : m1_if.ack), 32'd0);
  endtask

  task automatic dual(input string tag, input int k);
    logic [31:0] unused;
    logic [5:0]  a0, a1;
    logic [31:0] d0, d1;
    a0 = 6'(2 + 2 * k);
    a1 = 6'(3 + 2 * k);
    d0 = 32'h1122_3300 + 32'(k);
    d1 = 32'h99AA_BB00 + 32'(k);
    push_wb(1'b1, a0, d0, 4'hF, unused);
    push_wb(1'b1, a1, d1, 4'hF, unused);
    @(posedge clk) #1;
    set_req(0, 1'b1, 1'b1, a0, d0, 4'hF);
    set_req(1, 1'b1, 1'b1, a1, d1, 4'hF);
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (m0_if.ack | m1_if.ack) break;
    end
    chk({tag, " first ack m0"}, 32'(m0_if.ack), 32'd1);
    chk({tag, " first no m1 ack"}, 32'(m1_if.ack), 32'd0);
    m0_if.stb = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (m0_if.ack | m1_if.ack) break;
    end
    chk({tag, " second ack m1"}, 32'(m1_if.ack), 32'd1);
    chk({tag, " second no m0 ack"}, 32'(m0_if.ack), 32'd0);
    m1_if.stb = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int acks_seen;
    rst = 1'b1; mem_init = 1'b1;
    rf_waddr = '0; rf_raddr = '0; rf_wdata = '0; rf_wen = 1'b0; rf_ren = 1'b0;
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    for (int i = 0; i < 256; i++) model[i] = 8'(i) ^ 8'h5A;
    repeat (2) @(posedge clk);
    #1 mem_init = 1'b0;
    @(negedge clk);
    chk("reset m0 ack", 32'(m0_if.ack), 32'd0);
    chk("reset m1 ack", 32'(m1_if.ack), 32'd0);
    chk("reset rdt", m0_if.rdt, 32'd0);
    chk("reset sram wen", 32'(sram_wen), 32'd0);
    chk("reset sram ren", 32'(sram_ren), 32'd0);
    @(posedge clk) #1 rst = 1'b0;

    dual("dual0", 0);
    dual("dual1", 1);

    run_xfer("m0 write", 0, 1'b1, 6'h05, 32'hA1B2_C3D4, 4'hF, 32'h0);
    run_xfer("m0 read", 0, 1'b0, 6'h05, 32'h0, 4'h0, 32'h0);
    run_xfer("m1 write sel5", 1, 1'b1, 6'h06, 32'h5566_7788, 4'h5, 32'h0);
    run_xfer("m1 read sel5", 1, 1'b0, 6'h06, 32'h0, 4'hF, 32'h0);
    run_xfer("m0 read rf stall", 0, 1'b0, 6'h05, 32'h0, 4'hF, 32'h0000_000C);

    for (int k = 0; k < 5; k++) begin
      logic [6:0] a;
      logic [7:0] sa;
      a  = (k < 4) ? 7'(7'h7C + k) : 7'h04;
      sa = ~{1'b0, a};
      rq.push_back(sa);
      @(posedge clk) #1;
      rf_ren = 1'b1; rf_raddr = a;
      @(posedge clk) #1;
      rf_ren = 1'b0;
      @(negedge clk);
      chk("rf rdata", 32'(rf_rdata), (k < 4) ? 32'd0 : 32'(model[sa]));
    end

    begin
      logic [31:0] unused;
      push_wb(1'b1, 6'h09, 32'hDEAD_BEEF, 4'h3, unused);
      @(posedge clk) #1;
      set_req(0, 1'b1, 1'b1, 6'h09, 32'hDEAD_BEEF, 4'hF);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("rst mid wen", 32'(sram_wen), 32'd0);
      chk("rst mid ren", 32'(sram_ren), 32'd0);
      chk("rst mid rdt", m0_if.rdt, 32'd0);
      model[8'h26] = mem[8'h26];
      @(posedge clk) #1;
      set_req(0, 1'b0, 1'b0, '0, '0, '0);
      rst = 1'b0;
      acks_seen = 0;
      repeat (10) begin
        @(negedge clk);
        if (m0_if.ack | m1_if.ack) acks_seen++;
      end
      chk("rst mid no ack", 32'(acks_seen), 32'd0);
    end

    run_xfer("m1 write after rst", 1, 1'b1, 6'h0A, 32'h0BAD_F00D, 4'hF, 32'h0);
    run_xfer("m1 read after rst", 1, 1'b0, 6'h0A, 32'h0, 4'hF, 32'h0);

    chk("write queue drained", 32'(wq.size()), 32'd0);
    chk("read queue drained", 32'(rq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/servile_sram_wb_arbiter.md
Name: servile_sram_wb_arbiter

Overview:
- Shares one 8-bit SRAM between the serial RF port and two 32-bit Wishbone masters: m0 is the CPU data/instruction bus, m1 is the loader/debug bus.
- RF accesses always win the SRAM in the cycle they occur.
- Wishbone words are moved as four byte beats. Beats stall while the RF is active.
- Masters are arbitrated round-robin, with the grant held until ack.

Parameters:
- depth, 256: SRAM depth in bytes.
- rf_regs, 32: number of RF registers. The RF occupies the top rf_regs*4 bytes.
- rf_depth, $clog2(rf_regs*4): derived, do not override.
- aw, $clog2(depth): derived, do not override.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_rf_waddr, i_rf_raddr  in  rf_depth  RF byte addresses.
- i_rf_wdata  in  8  RF write byte.
- i_rf_wen, i_rf_ren  in  1  RF write/read enables.
- o_rf_rdata  out  8  RF read byte.
- o_sram_waddr, o_sram_raddr  out  aw  SRAM addresses.
- o_sram_wdata  out  8  SRAM write byte.
- o_sram_wen, o_sram_ren  out  1  SRAM enables.
- i_sram_rdata  in  8  SRAM read byte, valid one cycle after ren.
- i_m0_adr, i_m1_adr  in  aw-2  word address, bits [aw-1:2].
- i_m0_dat, i_m1_dat  in  32  write data.
- i_m0_sel, i_m1_sel  in  4  byte selects.
- i_m0_we, i_m1_we  in  1  write enable.
- i_m0_stb, i_m1_stb  in  1  request.
- o_m0_rdt, o_m1_rdt  out  32  registered read data. Shared register, driven to both.
- o_m0_ack, o_m1_ack  out  1  one-cycle ack.

Behaviour:
- Reset (async): state=IDLE, grant=0, last=1 (m0 wins first tie), beat=0, rd_pend=0, rdt=0, both acks 0, regzero=0.
- RF passthrough, combinational:
  - rf_active = i_rf_wen | i_rf_ren.
  - When rf_active, SRAM addresses are ~{0,i_rf_*addr}, zero-extended to aw. wdata/wen/ren come from the RF.
  - Otherwise the SRAM is driven by the current Wishbone beat, or idle (wen=ren=0).
- RF read data: regzero <= &i_rf_raddr[rf_depth-1:2] each cycle. o_rf_rdata = regzero ? 0 : i_sram_rdata.
- State machine:
  - IDLE: if any stb, grant the requester; on a tie, grant !last. Latch grant and go to XFER; beat=0.
  - XFER:
    - Each cycle with !rf_active, issue beat b: address {adr,b}.
    - Write beat: wdata=dat[8b+:8], wen=sel[b].
    - Read beat: ren=1.
    - Then beat<=beat+1. rf_active freezes the beat (no issue, no increment).
    - After beat 3: a write goes to ACK, a read goes to DRAIN.
  - DRAIN: one cycle. Final byte captured. Go to ACK.
  - ACK: ack of the granted master high for exactly one cycle; last<=grant. Go to IDLE. No arbitration occurs in ACK.
- Read capture:
  - rd_pend<=issued read beat; rd_idx<=b.
  - When rd_pend, rdt[8*rd_idx+:8]<=i_sram_rdata. Capture is independent of the current-cycle RF activity.
  - An RF read in DRAIN does not corrupt capture.
- Latency, no RF interference, stb sampled at edge E0:
  - Write: ack high in cycle 5.
  - Read: ack high in cycle 6, with rdt stable during ack.
  - Each RF-active cycle in XFER adds one cycle.
- Unselected write bytes still consume a beat (fixed 4 beats).
- Reads ignore sel.
- Masters must hold adr/dat/sel/we stable until ack. A stb dropped mid-transfer is ignored: the transfer completes and acks.
- Address overlap with the RF region is not checked; it is software's responsibility.
- Async reset mid-transfer: transfer abandoned, no ack, outputs return to reset/passthrough immediately.

Decomposition:
- Package servile_arb_pkg holds:
  - state enum (IDLE, XFER, DRAIN, ACK);
  - BEATS=4;
  - master index constants M0=0, M1=1.
- Sub-module servile_rr_arb2: 2-requester round-robin with a last-grant register. It is updated on an ack pulse input.

Test Plan:
- m0 write adr=0x05, dat=0xA1B2C3D4, sel=0xF, no RF activity -> SRAM wen at addresses 0x14..0x17 with bytes D4,C3,B2,A1. Ack in cycle 5, one cycle wide.
- m0 read of the same word -> ren at 0x14..0x17, o_m0_rdt=0xA1B2C3D4, ack in cycle 6.
- m1 write sel=0x5 -> wen only on beats 0 and 2, four beats total, ack at cycle 5.
- m0 and m1 stb together from reset -> m0 served first, m1 next.
- m0 and m1 stb together repeatedly -> grants alternate m0,m1,m0.
- RF write at raddr/waddr=0x00 pulsed during beats 1 and 2 of a read -> SRAM waddr=0xFF with the RF data in those cycles, read ack delayed to cycle 8, rdt still correct.
- RF read of register 31 (raddr 0x7C..0x7F) -> o_rf_rdata=0 regardless of SRAM contents.
- Assert i_rst in XFER beat 2 -> no ack ever, state IDLE. The next m1 request completes normally.
